// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end.
//   word_t        : 32-bit machine word
//   fetch_entry_t : one prefetch FIFO slot {instruction, PC+4}
//   FQ_DEPTH      : default prefetch FIFO depth
//   fetch_state_t : fetch FSM states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
  } fetch_entry_t;

  localparam int unsigned FQ_DEPTH = 2;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH-entry circular buffer of fetch_entry_t.
//   push/pop  : write tail / remove head (ignored when full/empty)
//   clear     : drop all entries at the next edge, overrides push and pop
//   full/empty: occupancy flags, derived from the registered count
//   head      : current head entry, read straight from storage registers
module fetch_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
//   CLK, nRST        : clock, async active-low reset
//   imemaddr / pcEN  : PC value in, PC advance/load enable out
//   halt             : sticky stop request
//   iREN/iaddr/ihit/iload : instruction cache request/response
//   flush            : redirect; clears queued and in-flight fetches
//   instr_o/npc_o/valid_o/ready_i : prefetch FIFO head to decode
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t imemaddr,
  output logic  pcEN,
  input  logic  halt,
  output logic  iREN,
  output word_t iaddr,
  input  logic  ihit,
  input  word_t iload,
  input  logic  flush,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o,
  input  logic  ready_i
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  fetch_entry_t push_data;
  fetch_entry_t head;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // nRST gates the request so a reset mid-miss drops iREN immediately.
  always_comb begin
    state_d = state_q;
    iREN    = 1'b0;
    pcEN    = 1'b0;
    push    = 1'b0;
    if (state_q == FETCH) begin
      if (halt) state_d = HALTED;
      iREN = nRST && !full && !flush;
      push = ihit && iREN;
      pcEN = nRST && (push || flush);
    end
  end

  assign iaddr     = imemaddr;
  assign push_data = '{instr: iload, npc: imemaddr + 32'd4};
  assign pop       = !empty && ready_i;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .clear    (flush),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign valid_o = !empty;
  assign instr_o = head.instr;
  assign npc_o   = head.npc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  word_t imemaddr;
  logic  pcEN;
  logic  halt;
  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;
  logic  flush;
  word_t instr_o;
  word_t npc_o;
  logic  valid_o;
  logic  ready_i;

  int unsigned n_vec;
  int unsigned n_err;

  fetch_unit #(
    .DEPTH(2)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .imemaddr(imemaddr),
    .pcEN    (pcEN),
    .halt    (halt),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .ihit    (ihit),
    .iload   (iload),
    .flush   (flush),
    .instr_o (instr_o),
    .npc_o   (npc_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    nRST = 1'b0; imemaddr = '0; halt = 1'b0; ihit = 1'b0;
    iload = '0; flush = 1'b0; ready_i = 1'b0;
    #2;
    chk("rst_iren",  32'(iREN),    32'd0);
    chk("rst_pcen",  32'(pcEN),    32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o,      32'd0);
    chk("rst_npc",   npc_o,        32'd0);
    do_reset();
    #1;
    chk("idle_iren", 32'(iREN), 32'd1);
    chk("idle_pcen", 32'(pcEN), 32'd0);

    // Single hit at PC 0, one-cycle latency to valid_o.
    tick();
    imemaddr = 32'h0; ihit = 1'b1; iload = 32'h20010005;
    #1;
    chk("t1_pcen",  32'(pcEN), 32'd1);
    chk("t1_iaddr", iaddr,     32'h0);
    tick();
    ihit = 1'b0;
    #1;
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_instr", instr_o,      32'h20010005);
    chk("t1_npc",   npc_o,        32'h4);
    chk("t1_hold_pcen", 32'(pcEN), 32'd0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    #1;
    chk("t1_drained", 32'(valid_o), 32'd0);

    // Fill to DEPTH with ready low; third request is blocked.
    imemaddr = 32'h0; ihit = 1'b1; iload = 32'hA0000000;
    tick();
    imemaddr = 32'h4; iload = 32'hA0000004;
    #1;
    chk("t2_pcen_2nd", 32'(pcEN), 32'd1);
    tick();
    imemaddr = 32'h8; iload = 32'hA0000008;
    #1;
    chk("t2_full_iren", 32'(iREN), 32'd0);
    chk("t2_full_pcen", 32'(pcEN), 32'd0);
    chk("t2_head_npc",  npc_o,     32'h4);
    ready_i = 1'b1;
    #1;
    chk("t2_popfull_iren", 32'(iREN), 32'd0);
    tick();
    ready_i = 1'b0;
    #1;
    chk("t2_resume_iren", 32'(iREN), 32'd1);
    chk("t2_resume_pcen", 32'(pcEN), 32'd1);
    chk("t2_head2_npc",   npc_o,     32'h8);
    chk("t2_head2_instr", instr_o,   32'hA0000004);
    tick();
    ihit = 1'b0;

    // Flush with two queued and a coincident hit: no push, FIFO empty.
    imemaddr = 32'h40; ihit = 1'b1; iload = 32'hBBBBBBBB; flush = 1'b1; ready_i = 1'b1;
    #1;
    chk("t3_flush_pcen", 32'(pcEN), 32'd1);
    chk("t3_flush_iren", 32'(iREN), 32'd0);
    tick();
    flush = 1'b0; ihit = 1'b0; ready_i = 1'b0;
    #1;
    chk("t3_valid", 32'(valid_o), 32'd0);
    chk("t3_iren_after", 32'(iREN), 32'd1);

    // PC+4 wraps at the top of the address space.
    imemaddr = 32'hFFFFFFFC; ihit = 1'b1; iload = 32'hDEADBEEF;
    tick();
    ihit = 1'b0;
    #1;
    chk("t4_wrap_npc",   npc_o,   32'h00000000);
    chk("t4_wrap_instr", instr_o, 32'hDEADBEEF);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;

    // Halt: queued entry delivered, coincident hit still pushed, then no more requests.
    imemaddr = 32'h100; ihit = 1'b1; iload = 32'h11111111;
    tick();
    imemaddr = 32'h104; iload = 32'h22222222; halt = 1'b1; ready_i = 1'b1;
    #1;
    chk("t5_halt_valid", 32'(valid_o), 32'd1);
    chk("t5_halt_instr", instr_o,      32'h11111111);
    chk("t5_halt_pcen",  32'(pcEN),    32'd1);
    tick();
    halt = 1'b0; ready_i = 1'b0;
    #1;
    chk("t5_pushed_valid", 32'(valid_o), 32'd1);
    chk("t5_pushed_instr", instr_o,      32'h22222222);
    chk("t5_pushed_npc",   npc_o,        32'h108);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    #1;
    chk("t5_drained", 32'(valid_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      chk("t5_halted_iren", 32'(iREN), 32'd0);
      chk("t5_halted_pcen", 32'(pcEN), 32'd0);
      tick();
    end
    flush = 1'b1;
    #1;
    chk("t5_halted_flush_pcen", 32'(pcEN), 32'd0);
    flush = 1'b0; ihit = 1'b0;

    // Reset during a miss: iREN and registered outputs drop before the next edge.
    do_reset();
    imemaddr = 32'h200; ihit = 1'b1; iload = 32'h33333333;
    tick();
    ihit = 1'b0;
    #1;
    chk("t6_pre_valid", 32'(valid_o), 32'd1);
    chk("t6_pre_iren",  32'(iREN),    32'd1);
    nRST = 1'b0;
    #1;
    chk("t6_iren",  32'(iREN),    32'd0);
    chk("t6_pcen",  32'(pcEN),    32'd0);
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_instr", instr_o,      32'd0);
    chk("t6_npc",   npc_o,        32'd0);
    tick();
    nRST = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the program counter. Each cycle it presents the current PC address (`imemaddr`) to the instruction cache and waits for `ihit`. On a hit it advances the PC via `pcEN` and queues {instruction, PC+4} into a small prefetch FIFO that feeds decode through a valid/ready handshake. It also discards in-flight and queued work on a pipeline flush and stops fetching permanently on halt.

## Interface
Parameters:
- `DEPTH`, 2, prefetch FIFO entries; power of two, ≥ 2.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `imemaddr`  in  word_t  current PC value from the PC block.
- `pcEN`  out  1  PC advance/load enable to the PC block.
- `halt`  in  1  halt request; sticky once sampled.
- `iREN`  out  1  instruction cache read request.
- `iaddr`  out  word_t  cache address; equals `imemaddr`.
- `ihit`  in  1  cache read complete this cycle.
- `iload`  in  word_t  instruction data, valid when `ihit`.
- `flush`  in  1  redirect from a later stage (taken branch/jump); PC target already on `pc_src`.
- `instr_o`  out  word_t  head-of-FIFO instruction.
- `npc_o`  out  word_t  head-of-FIFO PC+4.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  decode accepts head this cycle.

## Operation
- States: FETCH (reset state) and HALTED.
- FETCH: `iREN = !full && !flush`.
- HALTED: `iREN = 0`, `pcEN = 0`. Only `nRST` exits HALTED.
- Push: `ihit && iREN` writes {`iload`, `imemaddr + 4`}. The add is 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000.
- `pcEN = (ihit && iREN) || flush`, in FETCH only. On flush, `pcEN` loads the redirect target.
- Pop: `valid_o && ready_i` removes the head. `instr_o`/`npc_o` show the new head next cycle.
- Flush: all entries cleared at the next edge. A coincident `ihit` is discarded with no push. A coincident pop is ignored. `valid_o = 0` the next cycle.
- Halt: when `halt` is sampled high in FETCH, go to HALTED at the next edge. A coincident hit is still pushed. Queued entries keep draining to decode.
- Halt and flush in the same cycle: both act. FIFO cleared, state becomes HALTED.
- Full (count == DEPTH): `iREN = 0`, no PC advance. A pop while full frees a slot; the request resumes the following cycle.
- Empty: `valid_o = 0`. `ready_i` is ignored.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, order preserved.

## Timing
- Reset values:
  - state FETCH; count 0; read/write pointers 0.
  - `valid_o` 0, `instr_o` 0, `npc_o` 0.
  - While `nRST` is low, `iREN` 0 and `pcEN` 0.
- `iREN`, `iaddr`, `pcEN` are combinational from state, count, `flush`, `ihit`.
- `instr_o`, `npc_o`, `valid_o` are registered.
- Latency: `ihit` in cycle N gives `valid_o` = 1 in cycle N+1 when the FIFO was empty. No bypass.
- Throughput: one instruction per cycle when `ihit` is high every cycle and `ready_i` stays high.
- Address hold: while `ihit` = 0, `iaddr` is held stable because `pcEN` = 0.
- Reset mid-miss: `iREN` drops asynchronously and the outstanding request is abandoned. The cache controller must tolerate a dropped request.

## Structure
- In `cpu_types_pkg`:
  - `fetch_entry_t` packed struct {word_t instr; word_t npc;}.
  - `FQ_DEPTH` = 2 default constant.
- Sub-module `fetch_fifo`:
  - DEPTH-entry circular buffer of `fetch_entry_t`.
  - Ports: push, pop, clear, full, empty, head.
  - Count width `$clog2(DEPTH)+1`.
- `fetch_unit` holds the FSM, request/`pcEN` logic and registered outputs.

## Test plan
- Reset, then `imemaddr` = 0x0, `ihit` = 1 for one cycle with `iload` = 0x20010005 → `pcEN` = 1 that cycle; next cycle `valid_o` = 1, `instr_o` = 0x20010005, `npc_o` = 0x4.
- `ready_i` = 0, three consecutive hits at 0x0/0x4/0x8 with DEPTH = 2 → two entries queued; third cycle `iREN` = 0 and `pcEN` = 0. Raise `ready_i` → head `npc_o` = 0x4, then fetch of 0x8 resumes.
- Two entries queued, `flush` = 1 with `ihit` = 1 → `pcEN` = 1, no push; next cycle `valid_o` = 0, count 0.
- `halt` = 1 with one entry queued and `ready_i` = 1 → entry delivered next cycle. Afterwards `iREN` stays 0 for 10+ cycles despite `ihit` = 1.
- `imemaddr` = 0xFFFFFFFC hit → `npc_o` = 0x00000000.
- Assert `nRST` low mid-miss (`iREN` = 1, `ihit` = 0) → `iREN` = 0 immediately; all registered outputs 0 before the next edge.
